lif_neuron_scheduler: RTL and testbench

LIF_NEURON_SCHEDULER -- requirements
Module: lif_neuron_scheduler

---
 rtl/lif_pkg.sv | 23 ++
 rtl/mem_potential_acc.sv | 49 ++++
 rtl/lif_neuron_scheduler.sv | 115 +++++++++++
 tb/tb_lif_neuron_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/lif_pkg.sv
// Shared definitions for the LIF neuron scheduler: FSM state encoding and
// width helpers for the membrane potential and the neuron index.
package lif_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } lif_state_e;

  localparam int DEF_N_NEURONS = 4;
  localparam int DEF_N_STAGE   = 6;

  // Two guard bits above N_STAGE so leak plus input plus reset fits in one word.
  function automatic int pot_width(input int n_stage);
    return n_stage + 2;
  endfunction

  function automatic int idx_width(input int n_neurons);
    return (n_neurons > 1) ? $clog2(n_neurons) : 1;
  endfunction

endpackage

// File: rtl/mem_potential_acc.sv
// Membrane potential storage plus the shared leak/integrate/reset datapath.
// One neuron is updated per write; fire_o is the spike decision for the new value.
module mem_potential_acc import lif_pkg::*; #(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int W         = pot_width(DEF_N_STAGE),
  parameter int IW        = idx_width(DEF_N_NEURONS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   wr_en_i,
  input  logic [IW-1:0]          idx_i,
  input  logic signed [W-1:0]    sum_wx_i,
  input  logic [W-1:0]           threshold_i,
  input  logic [2:0]             beta_shift_i,
  input  logic                   spike_prev_i,
  output logic                   fire_o,
  output logic [N_NEURONS*W-1:0] u_o
);

  logic [W-1:0]        u_q [N_NEURONS];
  logic signed [W-1:0] u_cur;
  logic signed [W-1:0] acc;
  logic signed [W-1:0] u_new;

  // Leak by arithmetic shift, integrate, then subtract-reset if the neuron
  // fired last timestep; everything wraps modulo 2^W.
  always_comb begin
    u_cur  = u_q[idx_i];
    acc    = (u_cur >>> beta_shift_i) + sum_wx_i;
    u_new  = spike_prev_i ? (acc - $signed(threshold_i)) : acc;
    fire_o = !u_new[W-1] && ($unsigned(u_new) >= threshold_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_NEURONS; i++) u_q[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < N_NEURONS; i++) u_q[i] <= '0;
    end else if (wr_en_i) begin
      u_q[idx_i] <= u_new;
    end
  end

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_u_out
    assign u_o[g*W +: W] = u_q[g];
  end

endmodule

// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexed leaky integrate-and-fire layer: one start runs a timestep
// that fetches sum_wx for each neuron in index order and updates its potential.
module lif_neuron_scheduler import lif_pkg::*; #(
  parameter int N_NEURONS = DEF_N_NEURONS,
  parameter int N_STAGE   = DEF_N_STAGE
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                start,
  input  logic                                clr_state,
  input  logic [N_STAGE+1:0]                  threshold,
  input  logic [2:0]                          beta_shift,
  output logic                                sum_req,
  output logic [idx_width(N_NEURONS)-1:0]     neuron_idx,
  input  logic signed [N_STAGE+1:0]           sum_wx,
  input  logic                                sum_valid,
  output logic [N_NEURONS-1:0]                spikes,
  output logic                                busy,
  output logic                                done,
  output logic [1:0]                          dbg_state_o,
  output logic [N_NEURONS*(N_STAGE+2)-1:0]    dbg_u_o
);

  localparam int W  = pot_width(N_STAGE);
  localparam int IW = idx_width(N_NEURONS);

  lif_state_e           state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [N_NEURONS-1:0] spikes_q, spikes_d;
  logic [N_NEURONS-1:0] pend_q, pend_d;
  logic                 xfer;
  logic                 last;
  logic                 fire;
  logic                 clr;

  // Handshake: sum_req is high for the whole RUN state and never depends on
  // sum_valid; a transfer happens on any edge where sum_req && sum_valid, and
  // neuron_idx/sum_wx must pair up on that same edge.
  assign xfer = (state_q == ST_RUN) && sum_valid;
  assign last = (idx_q == IW'(N_NEURONS - 1));
  assign clr  = (state_q == ST_IDLE) && clr_state;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    spikes_d = spikes_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_state) begin
          pend_d   = '0;
          spikes_d = '0;
        end else if (start) begin
          state_d = ST_RUN;
          idx_d   = '0;
        end
      end
      ST_RUN: begin
        if (sum_valid) begin
          pend_d[idx_q] = fire;
          if (last) begin
            // Publish the whole vector at once so spikes stays stable during RUN.
            spikes_d = pend_d;
            idx_d    = '0;
            state_d  = ST_DONE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      spikes_q <= '0;
      pend_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      spikes_q <= spikes_d;
      pend_q   <= pend_d;
    end
  end

  mem_potential_acc #(
    .N_NEURONS (N_NEURONS),
    .W         (W),
    .IW        (IW)
  ) u_mem (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (clr),
    .wr_en_i      (xfer),
    .idx_i        (idx_q),
    .sum_wx_i     (sum_wx),
    .threshold_i  (threshold),
    .beta_shift_i (beta_shift),
    .spike_prev_i (spikes_q[idx_q]),
    .fire_o       (fire),
    .u_o          (dbg_u_o)
  );

  assign sum_req     = (state_q == ST_RUN);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign neuron_idx  = idx_q;
  assign spikes      = spikes_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler (4 neurons, 8-bit potentials):
// hand-computed spike/potential vectors are queued per timestep and checked on done.
module tb_lif_neuron_scheduler;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              clr_state = 1'b0;
  logic [7:0]        threshold = 8'd50;
  logic [2:0]        beta_shift = 3'd1;
  logic              sum_req;
  logic [1:0]        neuron_idx;
  logic signed [7:0] sum_wx = '0;
  logic              sum_valid = 1'b0;
  logic [3:0]        spikes;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;
  logic [31:0]       dbg_u;

  logic [3:0]  exp_spk_q[$];
  logic [31:0] exp_u_q[$];
  int n_cmp  = 0;
  int n_fail = 0;
  int n_done = 0;

  lif_neuron_scheduler #(.N_NEURONS(4), .N_STAGE(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .clr_state   (clr_state),
    .threshold   (threshold),
    .beta_shift  (beta_shift),
    .sum_req     (sum_req),
    .neuron_idx  (neuron_idx),
    .sum_wx      (sum_wx),
    .sum_valid   (sum_valid),
    .spikes      (spikes),
    .busy        (busy),
    .done        (done),
    .dbg_state_o (dbg_state),
    .dbg_u_o     (dbg_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every done pulse consumes one expected timestep result.
  initial begin
    forever begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (exp_spk_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_done: got done with no expected step, expected none");
        end else begin
          check("spikes_on_done", {28'd0, spikes}, {28'd0, exp_spk_q.pop_front()});
          check("u_on_done", dbg_u, exp_u_q.pop_front());
          check("busy_in_done", {31'd0, busy}, 32'd1);
        end
      end
    end
  end

  task automatic run_step(input logic [7:0] s0, input logic [7:0] s1,
                          input logic [7:0] s2, input logic [7:0] s3,
                          input logic [3:0] exp_spk, input logic [31:0] exp_u,
                          input int stall_idx, input int stall_n, input logic [7:0] stall_u,
                          input bit hold_start, input int exp_lat);
    logic [7:0] s [4];
    int cyc;
    int stalled;
    int d0;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    exp_spk_q.push_back(exp_spk);
    exp_u_q.push_back(exp_u);
    d0 = n_done;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = hold_start;
    cyc = 0;
    stalled = 0;
    while (!done && cyc < 50) begin
      if (sum_req) begin
        sum_wx = s[neuron_idx];
        if (int'(neuron_idx) == stall_idx && stalled < stall_n) begin
          sum_valid = 1'b0;
          stalled++;
          check("stall_req", {31'd0, sum_req}, 32'd1);
          check("stall_idx", {30'd0, neuron_idx}, stall_idx);
          check("stall_u", {24'd0, dbg_u[stall_idx*8 +: 8]}, {24'd0, stall_u});
        end else begin
          sum_valid = 1'b1;
        end
      end else begin
        sum_valid = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("done_latency", cyc, exp_lat);
    @(posedge clk); #1;
    start = 1'b0;
    sum_valid = 1'b0;
    check("idle_after_done", {31'd0, busy}, 32'd0);
    if (hold_start) begin
      repeat (3) @(posedge clk);
      #1;
      check("start_ignored_busy", {31'd0, busy}, 32'd0);
      check("single_done_pulse", n_done - d0, 1);
    end
  endtask

  task automatic clear_state(input bit with_start);
    @(posedge clk); #1 clr_state = 1'b1; start = with_start;
    @(posedge clk); #1 clr_state = 1'b0; start = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_spikes", {28'd0, spikes}, 32'd0);
    check("clr_u", dbg_u, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    check("rst_spikes", {28'd0, spikes}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_req", {31'd0, sum_req}, 32'd0);
    check("rst_idx", {30'd0, neuron_idx}, 32'd0);
    check("rst_u", dbg_u, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // Golden sequence with sum_wx=30: u = 30, 45, 52 (fire), 6.
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b0000, 32'h1E1E1E1E, -1, 0, 8'h00, 1'b0, 4);
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b0000, 32'h2D2D2D2D,  2, 3, 8'h1E, 1'b0, 7);
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b1111, 32'h34343434, -1, 0, 8'h00, 1'b0, 4);
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b0000, 32'h06060606, -1, 0, 8'h00, 1'b0, 4);
    // start held through RUN and DONE: u = 3+30 = 33, one done only.
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b0000, 32'h21212121, -1, 0, 8'h00, 1'b1, 4);
    // 16+40 = 56 fires, then clr_state with start wipes it and does not begin a step.
    run_step(8'd40, 8'd40, 8'd40, 8'd40, 4'b1111, 32'h38383838, -1, 0, 8'h00, 1'b0, 4);
    clear_state(1'b1);
    @(posedge clk); #1;
    check("clr_priority_busy", {31'd0, busy}, 32'd0);

    // Per-neuron ordering and threshold boundary: 10, 60, -5, 50 -> bits 1 and 3.
    run_step(8'd10, 8'd60, 8'hFB, 8'd50, 4'b1010, 32'h32FB3C0A, -1, 0, 8'h00, 1'b0, 4);
    clear_state(1'b0);
    run_step(8'hEC, 8'hEC, 8'hEC, 8'hEC, 4'b0000, 32'hECECECEC, -1, 0, 8'h00, 1'b0, 4);
    clear_state(1'b0);
    threshold = 8'd120;
    run_step(8'd100, 8'd100, 8'd100, 8'd100, 4'b0000, 32'h64646464, -1, 0, 8'h00, 1'b0, 4);
    threshold = 8'd50;
    // 50 + 100 = 150 wraps to -106: negative, so no spike.
    run_step(8'd100, 8'd100, 8'd100, 8'd100, 4'b0000, 32'h96969696, -1, 0, 8'h00, 1'b0, 4);

    // Reset asserted mid-timestep at neuron 1.
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0; sum_wx = 8'sd30; sum_valid = 1'b1;
    @(posedge clk); #1;
    check("midrst_idx_before", {30'd0, neuron_idx}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_req", {31'd0, sum_req}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    check("midrst_idx", {30'd0, neuron_idx}, 32'd0);
    check("midrst_spikes", {28'd0, spikes}, 32'd0);
    check("midrst_u", dbg_u, 32'd0);
    sum_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_step(8'd30, 8'd30, 8'd30, 8'd30, 4'b0000, 32'h1E1E1E1E, -1, 0, 8'h00, 1'b0, 4);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", exp_spk_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
